// File: rtl/branch_resolver.sv
// branch_resolver: branch outcome FIFO feeding predictor training, plus mispredict redirect/flush FSM.
// Optional BR_RESOLVER_STAT_EN adds saturating br_cnt/mp_cnt statistics outputs.
module branch_resolver #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rs_ena,
  input  logic              rs_tk,
  input  logic              rs_pd_tk,
  input  logic [ADDR_W-1:0] rs_pc,
  input  logic [ADDR_W-1:0] rs_tgt,
  input  logic [ADDR_W-1:0] rs_npc,
  output logic              rs_rdy,
  output logic              fb_ena,
  output logic              fb_tk,
  output logic [ADDR_W-1:0] fb_pc,
  output logic              rd_ena,
  output logic              flush,
  output logic [ADDR_W-1:0] rd_pc
`ifdef BR_RESOLVER_STAT_EN
  ,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mp_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic {RUN, REDIR} state_t;
  state_t state, state_nx;
  logic [ADDR_W:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic acc, pop, mis;
  assign rs_rdy = (state == RUN) && (count != (PW+1)'(FIFO_DEPTH));
  assign acc = rdy & rs_ena & rs_rdy;
  assign pop = rdy & (count != '0);
  assign mis = acc & (rs_tk ^ rs_pd_tk);
  assign rd_ena = (state == REDIR);
  assign flush = rd_ena;
  // A mispredict can only be accepted in RUN, and REDIR always leaves on the next ready edge.
  always_comb begin
    state_nx = rdy ? (mis ? REDIR : RUN) : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (acc) mem[wr_ptr] <= {rs_pc, rs_tk};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fb_ena <= 1'b0;
      fb_tk  <= 1'b0;
      fb_pc  <= '0;
      rd_pc  <= '0;
    end else begin
      fb_ena <= pop;
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        {fb_pc, fb_tk} <= mem[rd_ptr];
      end
      count <= count + (PW+1)'(acc) - (PW+1)'(pop);
      if (mis) rd_pc <= rs_tk ? rs_tgt : rs_npc;
    end
  end
`ifdef BR_RESOLVER_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (acc && ~&br_cnt) br_cnt <= br_cnt + 1'b1;
      if (mis && ~&mp_cnt) mp_cnt <= mp_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: queue-based reference model with a scoreboard-driven feedback monitor.
module tb_branch_resolver;
  localparam int A = 32;
  localparam int D = 4;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic rs_ena = 1'b0, rs_tk = 1'b0, rs_pd_tk = 1'b0;
  logic [A-1:0] rs_pc = '0, rs_tgt = '0, rs_npc = '0;
  logic rs_rdy, fb_ena, fb_tk, rd_ena, flush;
  logic [A-1:0] fb_pc, rd_pc;
`ifdef BR_RESOLVER_STAT_EN
  logic [31:0] br_cnt, mp_cnt;
  logic [31:0] m_br = '0, m_mp = '0;
`endif
  branch_resolver #(.FIFO_DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_ena(rs_ena), .rs_tk(rs_tk), .rs_pd_tk(rs_pd_tk),
    .rs_pc(rs_pc), .rs_tgt(rs_tgt), .rs_npc(rs_npc), .rs_rdy(rs_rdy),
    .fb_ena(fb_ena), .fb_tk(fb_tk), .fb_pc(fb_pc), .rd_ena(rd_ena), .flush(flush), .rd_pc(rd_pc)
`ifdef BR_RESOLVER_STAT_EN
    , .br_cnt(br_cnt), .mp_cnt(mp_cnt)
`endif
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  logic armed = 1'b0;
  logic [A:0] mq[$];
  logic [A:0] scb[$];
  logic m_redir = 1'b0, m_fb = 1'b0;
  logic [A-1:0] m_rdpc = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: branch outcomes sit in a queue until a ready edge hands the oldest to feedback.
  initial begin
    logic acc;
    logic [A:0] e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mq.delete(); scb.delete();
        m_redir = 1'b0; m_fb = 1'b0; m_rdpc = '0;
`ifdef BR_RESOLVER_STAT_EN
        m_br = '0; m_mp = '0;
`endif
      end else if (rdy) begin
        acc = rs_ena && !m_redir && mq.size() < D;
        m_fb = mq.size() > 0;
        if (m_fb) begin
          e = mq.pop_front();
          scb.push_back(e);
        end
        if (m_redir) m_redir = 1'b0;
        else if (acc && rs_tk != rs_pd_tk) begin
          m_redir = 1'b1;
          m_rdpc = rs_tk ? rs_tgt : rs_npc;
        end
        if (acc) mq.push_back({rs_pc, rs_tk});
`ifdef BR_RESOLVER_STAT_EN
        if (acc) m_br = m_br + 1;
        if (acc && rs_tk != rs_pd_tk) m_mp = m_mp + 1;
`endif
      end else m_fb = 1'b0;
      armed = 1'b1;
    end
  end
  initial begin
    logic [A:0] e;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("fb_ena", fb_ena, m_fb);
        if (fb_ena) begin
          if (scb.size() == 0) chk("fb_unexpected", 1, 0);
          else begin
            e = scb.pop_front();
            chk("fb_pc", fb_pc, e[A:1]);
            chk("fb_tk", fb_tk, e[0]);
          end
        end
        chk("rs_rdy", rs_rdy, !m_redir && mq.size() < D);
        chk("rd_ena", rd_ena, m_redir);
        chk("flush", flush, m_redir);
        chk("rd_pc", rd_pc, m_rdpc);
`ifdef BR_RESOLVER_STAT_EN
        chk("br_cnt", br_cnt, m_br);
        chk("mp_cnt", mp_cnt, m_mp);
`endif
      end
    end
  end
  task automatic step(input logic r, input logic en, input logic tk, input logic pd,
                      input logic [A-1:0] pc, input logic [A-1:0] tgt, input logic [A-1:0] npc);
    rdy = r; rs_ena = en; rs_tk = tk; rs_pd_tk = pd; rs_pc = pc; rs_tgt = tgt; rs_npc = npc;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask
  initial begin
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    idle(1);
    step(1, 1, 1, 1, 32'h100, 32'h180, 32'h104);
    idle(3);
    step(1, 1, 1, 0, 32'h200, 32'h280, 32'h204);
    step(1, 1, 1, 1, 32'h2a0, 32'h2b0, 32'h2a4);
    idle(3);
    step(1, 1, 0, 1, 32'h300, 32'h380, 32'h304);
    idle(3);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 32'h400 + 4*i, '0, '0);
    for (int i = 0; i < 6; i++) step(1, 1, i[0], i[0], 32'h500 + 4*i, '0, '0);
    idle(3);
    step(1, 1, 0, 1, 32'h600, 32'h680, 32'h604);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 32'h700, '0, '0);
    idle(3);
    step(1, 1, 1, 1, 32'h800, '0, '0);
    step(1, 1, 1, 0, 32'h804, 32'h880, 32'h808);
    rst = 1'b0;
    step(1, 1, 1, 1, 32'h900, '0, '0);
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
    end
    rst = 1'b1;
    idle(6);
    chk("scb_drained", scb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
